tile_rd_sched: RTL and testbench

Sequencer for multi-dimensional tile reads in the CNN accelerator. It walks a four-level loop nest (innermost level 0) and issues one read request per point over a valid/ready channel. Each request address is base + Σ cntK·SK. The block sits between the layer controller, which supplies start and base_addr, and the on-chip buffer or memory read port. It replaces free-running nested counters where downstream backpressure must stall the traversal.

---
 rtl/tile_rd_sched.sv | 189 ++++++++++++++++++
 tb/tb_tile_rd_sched.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_rd_sched.sv
// Four-level loop-nest read sequencer: one valid/ready request per tile point.
// Optional backpressure counter on stall_cnt when TILE_RD_SCHED_STALL_CNT_EN is defined.
module tile_rd_sched #(
  parameter int unsigned AW = 32,
  parameter int unsigned CW = 16,
  parameter int unsigned N0 = 4,
  parameter int unsigned N1 = 2,
  parameter int unsigned N2 = 2,
  parameter int unsigned N3 = 3,
  parameter int unsigned S0 = 1,
  parameter int unsigned S1 = 4,
  parameter int unsigned S2 = 8,
  parameter int unsigned S3 = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [AW-1:0] base_addr,
  output logic          busy,
  output logic          done,
  output logic          req_valid,
  input  logic          req_ready,
  output logic [AW-1:0] req_addr,
  output logic          req_last,
  output logic [CW-1:0] cnt0,
  output logic [CW-1:0] cnt1,
  output logic [CW-1:0] cnt2,
  output logic [CW-1:0] cnt3
`ifdef TILE_RD_SCHED_STALL_CNT_EN
  ,
  output logic [31:0]   stall_cnt
`endif
);

  localparam logic [AW-1:0] ST0 = AW'(S0);
  localparam logic [AW-1:0] ST1 = AW'(S1);
  localparam logic [AW-1:0] ST2 = AW'(S2);
  localparam logic [AW-1:0] ST3 = AW'(S3);
  localparam logic [CW-1:0] L0  = CW'(N0 - 1);
  localparam logic [CW-1:0] L1  = CW'(N1 - 1);
  localparam logic [CW-1:0] L2  = CW'(N2 - 1);
  localparam logic [CW-1:0] L3  = CW'(N3 - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt0, r_cnt1, r_cnt2, r_cnt3;
  logic [AW-1:0] r_addr;
  // Running partial sums: r_rowK = base + sum of cntJ*SJ for J > K
  logic [AW-1:0] r_row0, r_row1, r_row2;
  logic          r_done;
  logic          w_start_ok;
  logic          w_hs;
  logic          w_last;
  logic [AW-1:0] w_row0_n, w_row1_n, w_row2_n;

  assign w_start_ok = (r_state == IDLE) && start && !abort;
  assign w_last     = (r_state == RUN) && (r_cnt0 == L0) && (r_cnt1 == L1) &&
                      (r_cnt2 == L2) && (r_cnt3 == L3);
  assign w_hs       = (r_state == RUN) && req_ready;
  assign w_row0_n   = r_row0 + ST1;
  assign w_row1_n   = r_row1 + ST2;
  assign w_row2_n   = r_row2 + ST3;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic; abort wins over a simultaneous handshake
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_start_ok) w_next = RUN;
      RUN: begin
        if (abort)                w_next = IDLE;
        else if (w_hs && w_last)  w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Output decode from the state flop and registered counters
  always_comb begin
    busy      = 1'b0;
    req_valid = 1'b0;
    req_last  = 1'b0;
    if (r_state == RUN) begin
      busy      = 1'b1;
      req_valid = 1'b1;
      req_last  = w_last;
    end
  end

  // Counter and address datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
      r_cnt2 <= '0;
      r_cnt3 <= '0;
      r_addr <= '0;
      r_row0 <= '0;
      r_row1 <= '0;
      r_row2 <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == IDLE) begin
        if (w_start_ok) begin
          r_cnt0 <= '0;
          r_cnt1 <= '0;
          r_cnt2 <= '0;
          r_cnt3 <= '0;
          r_addr <= base_addr;
          r_row0 <= base_addr;
          r_row1 <= base_addr;
          r_row2 <= base_addr;
        end
      end else if (abort) begin
        r_cnt0 <= '0;
        r_cnt1 <= '0;
        r_cnt2 <= '0;
        r_cnt3 <= '0;
      end else if (w_hs) begin
        if (w_last) begin
          r_cnt0 <= '0;
          r_cnt1 <= '0;
          r_cnt2 <= '0;
          r_cnt3 <= '0;
          r_done <= 1'b1;
        end else if (r_cnt0 != L0) begin
          r_cnt0 <= r_cnt0 + CW'(1);
          r_addr <= r_addr + ST0;
        end else begin
          r_cnt0 <= '0;
          if (r_cnt1 != L1) begin
            r_cnt1 <= r_cnt1 + CW'(1);
            r_row0 <= w_row0_n;
            r_addr <= w_row0_n;
          end else begin
            r_cnt1 <= '0;
            if (r_cnt2 != L2) begin
              r_cnt2 <= r_cnt2 + CW'(1);
              r_row1 <= w_row1_n;
              r_row0 <= w_row1_n;
              r_addr <= w_row1_n;
            end else begin
              r_cnt2 <= '0;
              r_cnt3 <= r_cnt3 + CW'(1);
              r_row2 <= w_row2_n;
              r_row1 <= w_row2_n;
              r_row0 <= w_row2_n;
              r_addr <= w_row2_n;
            end
          end
        end
      end
    end
  end

  assign done     = r_done;
  assign req_addr = r_addr;
  assign cnt0     = r_cnt0;
  assign cnt1     = r_cnt1;
  assign cnt2     = r_cnt2;
  assign cnt3     = r_cnt3;

`ifdef TILE_RD_SCHED_STALL_CNT_EN
  logic [31:0] r_stall;

  // Saturating count of cycles with a presented but unaccepted request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall <= '0;
    end else if (w_start_ok) begin
      r_stall <= '0;
    end else if ((r_state == RUN) && !req_ready && (r_stall != 32'hFFFF_FFFF)) begin
      r_stall <= r_stall + 32'(1);
    end
  end

  assign stall_cnt = r_stall;
`endif

endmodule

// File: tb/tb_tile_rd_sched.sv
// Self-checking bench for tile_rd_sched: randomized backpressure against a loop-nest model.
module tb_tile_rd_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_a, abort_a, ready_a;
  logic [31:0] base_a;
  logic        busy_a, done_a, valid_a, last_a;
  logic [31:0] addr_a;
  logic [15:0] c0_a, c1_a, c2_a, c3_a;
  logic        start_b, abort_b, ready_b;
  logic [31:0] base_b;
  logic        busy_b, done_b, valid_b, last_b;
  logic [31:0] addr_b;
  logic [15:0] c0_b, c1_b, c2_b, c3_b;
`ifdef TILE_RD_SCHED_STALL_CNT_EN
  logic [31:0] stall_a, stall_b;
`endif

  int total = 0;
  int bad   = 0;
  logic [31:0] q_addr[$];
  logic [63:0] q_cnt[$];

  always #5 clk = ~clk;

  tile_rd_sched dut (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .base_addr(base_a),
    .busy(busy_a), .done(done_a), .req_valid(valid_a), .req_ready(ready_a),
    .req_addr(addr_a), .req_last(last_a),
    .cnt0(c0_a), .cnt1(c1_a), .cnt2(c2_a), .cnt3(c3_a)
`ifdef TILE_RD_SCHED_STALL_CNT_EN
    , .stall_cnt(stall_a)
`endif
  );

  tile_rd_sched #(.N0(1), .N1(1), .N2(1), .N3(5), .S3(32'h40)) dut5 (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .base_addr(base_b),
    .busy(busy_b), .done(done_b), .req_valid(valid_b), .req_ready(ready_b),
    .req_addr(addr_b), .req_last(last_b),
    .cnt0(c0_b), .cnt1(c1_b), .cnt2(c2_b), .cnt3(c3_b)
`ifdef TILE_RD_SCHED_STALL_CNT_EN
    , .stall_cnt(stall_b)
`endif
  );

  // Reference: enumerate the loop nest directly, outermost first
  function automatic void build(input logic [31:0] base, input int n0, n1, n2, n3,
                                input int s0, s1, s2, s3);
    q_addr.delete();
    q_cnt.delete();
    for (int i3 = 0; i3 < n3; i3++)
      for (int i2 = 0; i2 < n2; i2++)
        for (int i1 = 0; i1 < n1; i1++)
          for (int i0 = 0; i0 < n0; i0++) begin
            q_addr.push_back(base + 32'(i0 * s0 + i1 * s1 + i2 * s2 + i3 * s3));
            q_cnt.push_back({16'(i3), 16'(i2), 16'(i1), 16'(i0)});
          end
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_a_at(input logic [31:0] b);
    base_a  = b;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    total++;
    if ({busy_a, done_a, valid_a, last_a, addr_a, c3_a, c2_a, c1_a, c0_a} !== '0) begin
      bad++;
      $display("FAIL reset_a got=%b/%b/%b/%b addr=%h", busy_a, done_a, valid_a, last_a, addr_a);
    end
    total++;
    if ({busy_b, done_b, valid_b, last_b, addr_b, c3_b, c2_b, c1_b, c0_b} !== '0) begin
      bad++;
      $display("FAIL reset_b got=%b/%b/%b/%b addr=%h", busy_b, done_b, valid_b, last_b, addr_b);
    end
`ifdef TILE_RD_SCHED_STALL_CNT_EN
    total++;
    if (stall_a !== 32'd0) begin bad++; $display("FAIL reset_stall got=%0d exp=0", stall_a); end
`endif
    rst = 1'b0;
    tick();
  endtask

  // mode 0: ready always 1; mode 1: ready 0,1,0,1...; mode 2: random ready
  task automatic test_stream(input int mode);
    int idx = 0, cyc = 0, busy_cyc = 0, stalls = 0;
    logic held = 1'b0;
    logic [31:0] prev_addr = '0;
    build(32'h1000, 4, 2, 2, 3, 1, 4, 8, 16);
    start_a_at(32'h1000);
    while (idx < q_addr.size() && cyc < 1000) begin
      ready_a = (mode == 0) ? 1'b1 : (mode == 1) ? 1'(cyc % 2) : 1'($urandom_range(0, 1));
      if (busy_a) busy_cyc++;
      if (held) begin
        total++;
        if (addr_a !== prev_addr) begin
          bad++; $display("FAIL hold_addr m=%0d got=%h exp=%h", mode, addr_a, prev_addr);
        end
      end
      total++;
      if (valid_a !== 1'b1) begin
        bad++; $display("FAIL valid_drop m=%0d idx=%0d got=%b exp=1", mode, idx, valid_a);
        break;
      end
      held = !ready_a;
      prev_addr = addr_a;
      if (ready_a) begin
        total++;
        if (addr_a !== q_addr[idx] || {c3_a, c2_a, c1_a, c0_a} !== q_cnt[idx] ||
            last_a !== (idx == q_addr.size() - 1)) begin
          bad++;
          $display("FAIL req m=%0d idx=%0d got=%h/%h/%b exp=%h/%h/%b", mode, idx, addr_a,
                   {c3_a, c2_a, c1_a, c0_a}, last_a, q_addr[idx], q_cnt[idx],
                   idx == q_addr.size() - 1);
        end
        idx++;
      end else begin
        stalls++;
      end
      tick();
      cyc++;
    end
    ready_a = 1'b0;
    total++;
    if (idx != q_addr.size()) begin bad++; $display("FAIL timeout m=%0d got=%0d exp=48", mode, idx); end
    total++;
    if ({done_a, valid_a, busy_a} !== 3'b100) begin
      bad++; $display("FAIL done_cycle m=%0d got=%b exp=100", mode, {done_a, valid_a, busy_a});
    end
    if (mode != 2) begin
      total++;
      if (busy_cyc != ((mode == 0) ? 48 : 96)) begin
        bad++; $display("FAIL busy_len m=%0d got=%0d exp=%0d", mode, busy_cyc, (mode == 0) ? 48 : 96);
      end
    end
`ifdef TILE_RD_SCHED_STALL_CNT_EN
    total++;
    if (stall_a !== 32'(stalls)) begin bad++; $display("FAIL stall_cnt got=%0d exp=%0d", stall_a, stalls); end
`endif
    tick();
    total++;
    if (done_a !== 1'b0) begin bad++; $display("FAIL done_pulse got=%b exp=0", done_a); end
  endtask

  task automatic test_back_to_back;
    int idx = 0, cyc = 0;
    build(32'h1000, 4, 2, 2, 3, 1, 4, 8, 16);
    start_a_at(32'h1000);
    ready_a = 1'b1;
    while (idx < 48 && cyc < 200) begin
      start_a = (idx == 10);
      base_a  = 32'h3000;
      total++;
      if (valid_a !== 1'b1 || addr_a !== q_addr[idx]) begin
        bad++; $display("FAIL b2b_req idx=%0d got=%b/%h exp=1/%h", idx, valid_a, addr_a, q_addr[idx]);
      end
      idx++;
      tick();
      cyc++;
    end
    start_a = 1'b0;
    total++;
    if (done_a !== 1'b1) begin bad++; $display("FAIL b2b_done got=%b exp=1", done_a); end
    ready_a = 1'b0;
    start_a_at(32'h2000);
    total++;
    if ({valid_a, addr_a, c3_a, c2_a, c1_a, c0_a} !== {1'b1, 32'h2000, 64'd0}) begin
      bad++; $display("FAIL b2b_restart got=%b/%h exp=1/00002000", valid_a, addr_a);
    end
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
  endtask

  task automatic test_abort;
    int idx = 0;
    start_a_at(32'h1000);
    ready_a = 1'b1;
    while (idx < 19) begin idx++; tick(); end
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    ready_a = 1'b0;
    total++;
    if ({valid_a, busy_a, done_a, c3_a, c2_a, c1_a, c0_a} !== '0) begin
      bad++; $display("FAIL abort got=%b/%b/%b cnt=%h exp=0", valid_a, busy_a, done_a,
                      {c3_a, c2_a, c1_a, c0_a});
    end
    tick();
    total++;
    if (done_a !== 1'b0) begin bad++; $display("FAIL abort_nodone got=%b exp=0", done_a); end
    start_a = 1'b1;
    abort_a = 1'b1;
    base_a  = 32'h5000;
    tick();
    start_a = 1'b0;
    abort_a = 1'b0;
    total++;
    if (valid_a !== 1'b0) begin bad++; $display("FAIL abort_blocks_start got=%b exp=0", valid_a); end
    start_a_at(32'h1000);
    total++;
    if ({valid_a, addr_a, c0_a} !== {1'b1, 32'h1000, 16'd0}) begin
      bad++; $display("FAIL abort_restart got=%b/%h exp=1/00001000", valid_a, addr_a);
    end
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
  endtask

  task automatic test_rst_mid;
    int idx = 0;
    start_a_at(32'h1000);
    ready_a = 1'b1;
    while (idx < 30) begin idx++; tick(); end
    rst = 1'b1;
    #1;
    total++;
    if ({busy_a, done_a, valid_a, last_a, addr_a, c3_a, c2_a, c1_a, c0_a} !== '0) begin
      bad++; $display("FAIL rst_async got=%b/%b/%b addr=%h exp=0", busy_a, valid_a, last_a, addr_a);
    end
    tick();
    rst = 1'b0;
    ready_a = 1'b0;
    tick();
    total++;
    if ({done_a, valid_a} !== 2'b00) begin bad++; $display("FAIL rst_nodone got=%b exp=00", {done_a, valid_a}); end
  endtask

  task automatic test_override;
    int idx = 0, cyc = 0;
    build(32'h0, 1, 1, 1, 5, 1, 4, 8, 32'h40);
    base_b  = 32'h0;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    while (idx < q_addr.size() && cyc < 100) begin
      ready_b = 1'($urandom_range(0, 1));
      if (ready_b && valid_b) begin
        total++;
        if (addr_b !== q_addr[idx] || last_b !== (idx == 4) || {c3_b, c2_b, c1_b, c0_b} !== q_cnt[idx]) begin
          bad++; $display("FAIL ovr idx=%0d got=%h/%b exp=%h/%b", idx, addr_b, last_b, q_addr[idx], idx == 4);
        end
        idx++;
      end
      tick();
      cyc++;
    end
    ready_b = 1'b0;
    total++;
    if (idx != 5 || done_b !== 1'b1) begin bad++; $display("FAIL ovr_done got=%0d/%b exp=5/1", idx, done_b); end
  endtask

  initial begin
    rst = 1'b1;
    {start_a, abort_a, ready_a, start_b, abort_b, ready_b} = '0;
    base_a = '0;
    base_b = '0;
    test_reset();
    test_stream(0);
    test_stream(1);
    test_stream(2);
    test_back_to_back();
    test_abort();
    test_rst_mid();
    test_stream(2);
    test_override();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
